// File: rtl/uart_rx_pkg.sv
// Shared types and timing offsets for the UART RX frame controller.
// Sample/decision offsets are relative to the mid-bit edge M = P/2.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam int SAMPLE_OFS_0 = -2;
  localparam int SAMPLE_OFS_1 = -1;
  localparam int SAMPLE_OFS_2 = 0;
  localparam int DECIDE_OFS   = 1;
  localparam int PRESC_MIN    = 8;

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// Serial-side, sampler-side and parallel-side signals of the RX frame controller.
interface uart_rx_frame_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
);
  logic                  RX_IN;
  logic                  OUT_Sample;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [PRESC_W-1:0]    Prescale;
  logic                  take_sample_w;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  Par_Err;
  logic                  Stp_Err;
  logic                  Start_Glitch;
  logic                  Rx_Busy;

  modport slave (
    input  RX_IN, OUT_Sample, PAR_EN, PAR_TYP, Prescale,
    output take_sample_w, P_DATA, Data_Valid, Par_Err, Stp_Err, Start_Glitch, Rx_Busy
  );

  modport master (
    output RX_IN, OUT_Sample, PAR_EN, PAR_TYP, Prescale,
    input  take_sample_w, P_DATA, Data_Valid, Par_Err, Stp_Err, Start_Glitch, Rx_Busy
  );
endinterface

// File: rtl/uart_rx_edge_bit_counter.sv
// Per-bit edge counter (0..P-1) and data bit index, with bit-end and
// decision-point compares against the latched prescale.
module uart_rx_edge_bit_counter
  import uart_rx_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int PRESC_W    = 6,
  localparam int BW         = $clog2(DATA_WIDTH)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [PRESC_W-1:0] i_presc,
  input  logic               i_edge_en,
  input  logic               i_edge_clr,
  input  logic               i_bit_clr,
  input  logic               i_bit_inc,
  output logic [PRESC_W-1:0] o_edge_cnt,
  output logic [BW-1:0]      o_bit_cnt,
  output logic               o_bit_end,
  output logic               o_decision_pt
);

  logic [PRESC_W-1:0] r_edge_cnt;
  logic [BW-1:0]      r_bit_cnt;
  logic [PRESC_W-1:0] w_m;

  assign w_m           = {1'b0, i_presc[PRESC_W-1:1]};
  assign o_bit_end     = (r_edge_cnt == (i_presc - PRESC_W'(1)));
  assign o_decision_pt = (r_edge_cnt == (w_m + PRESC_W'(DECIDE_OFS)));
  assign o_edge_cnt    = r_edge_cnt;
  assign o_bit_cnt     = r_bit_cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end else begin
      if (i_edge_clr)     r_edge_cnt <= '0;
      else if (i_edge_en) r_edge_cnt <= o_bit_end ? '0 : r_edge_cnt + PRESC_W'(1);
      if (i_bit_clr)      r_bit_cnt  <= '0;
      else if (i_bit_inc) r_bit_cnt  <= r_bit_cnt + BW'(1);
    end
  end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART RX frame controller: start detect, sampler strobes, LSB-first
// deserialization, parity/stop checks and one-cycle outcome pulses.
module uart_rx_frame_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input logic CLK,
  input logic RST,
  uart_rx_frame_ctrl_if.slave bus
);

  localparam int BW = $clog2(DATA_WIDTH);

  rx_state_e             r_state;
  logic [PRESC_W-1:0]    r_presc;
  logic                  r_par_en, r_par_typ, r_par_fail;
  logic [DATA_WIDTH-1:0] r_shadow, r_p_data;
  logic                  r_dv, r_pe, r_se, r_sg;

  logic [PRESC_W-1:0]    w_presc_in, w_m, w_edge_cnt;
  logic [BW-1:0]         w_bit_cnt;
  logic                  w_bit_end, w_decision, w_bit_last;
  logic                  w_start_det, w_glitch, w_stop_done, w_exp_par, w_good;

  // Out-of-range prescale is forced to the nearest legal even value >= 8.
  assign w_presc_in  = (bus.Prescale < PRESC_W'(PRESC_MIN)) ? PRESC_W'(PRESC_MIN)
                                                             : {bus.Prescale[PRESC_W-1:1], 1'b0};
  assign w_m         = {1'b0, r_presc[PRESC_W-1:1]};
  assign w_start_det = (r_state == IDLE) && !bus.RX_IN;
  assign w_glitch    = (r_state == START) && w_decision && bus.OUT_Sample;
  assign w_stop_done = (r_state == STOP) && w_decision;
  assign w_bit_last  = (w_bit_cnt == BW'(DATA_WIDTH - 1));
  assign w_exp_par   = (^r_shadow) ^ r_par_typ;
  assign w_good      = !r_par_fail && bus.OUT_Sample;

  uart_rx_edge_bit_counter #(.DATA_WIDTH(DATA_WIDTH), .PRESC_W(PRESC_W)) u_cnt (
    .CLK          (CLK),
    .RST          (RST),
    .i_presc      (r_presc),
    .i_edge_en    ((r_state != IDLE) || w_start_det),
    .i_edge_clr   (w_glitch || w_stop_done),
    .i_bit_clr    (r_state == START),
    .i_bit_inc    ((r_state == DATA) && w_bit_end),
    .o_edge_cnt   (w_edge_cnt),
    .o_bit_cnt    (w_bit_cnt),
    .o_bit_end    (w_bit_end),
    .o_decision_pt(w_decision)
  );

  assign bus.take_sample_w = (r_state != IDLE) &&
                             ((w_edge_cnt == w_m + PRESC_W'(SAMPLE_OFS_0)) ||
                              (w_edge_cnt == w_m + PRESC_W'(SAMPLE_OFS_1)) ||
                              (w_edge_cnt == w_m + PRESC_W'(SAMPLE_OFS_2)));
  assign bus.P_DATA        = r_p_data;
  assign bus.Data_Valid    = r_dv;
  assign bus.Par_Err       = r_pe;
  assign bus.Stp_Err       = r_se;
  assign bus.Start_Glitch  = r_sg;
  assign bus.Rx_Busy       = (r_state != IDLE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= IDLE;
      r_presc    <= PRESC_W'(PRESC_MIN);
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
      r_par_fail <= 1'b0;
      r_shadow   <= '0;
      r_p_data   <= '0;
      r_dv       <= 1'b0;
      r_pe       <= 1'b0;
      r_se       <= 1'b0;
      r_sg       <= 1'b0;
    end else begin
      r_dv <= 1'b0;
      r_pe <= 1'b0;
      r_se <= 1'b0;
      r_sg <= 1'b0;
      case (r_state)
        IDLE: if (w_start_det) begin
          r_state    <= START;
          r_presc    <= w_presc_in;
          r_par_en   <= bus.PAR_EN;
          r_par_typ  <= bus.PAR_TYP;
          r_par_fail <= 1'b0;
        end
        START: begin
          if (w_glitch) begin
            r_state <= IDLE;
            r_sg    <= 1'b1;
          end else if (w_bit_end) begin
            r_state <= DATA;
          end
        end
        DATA: begin
          if (w_decision) r_shadow[w_bit_cnt] <= bus.OUT_Sample;
          if (w_bit_end && w_bit_last) r_state <= r_par_en ? PARITY : STOP;
        end
        PARITY: begin
          if (w_decision) r_par_fail <= (bus.OUT_Sample != w_exp_par);
          if (w_bit_end)  r_state    <= STOP;
        end
        // Leaving at the decision edge leaves half a bit to catch a back-to-back start.
        STOP: if (w_stop_done) begin
          r_state <= IDLE;
          r_dv    <= w_good;
          r_pe    <= r_par_fail;
          r_se    <= !bus.OUT_Sample;
          if (w_good) r_p_data <= r_shadow;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
